// File: rtl/axi4_reg_slice.sv
// ============================================================================
// axi4_reg_slice : per-channel configurable AXI4 register slice (bypass/full/light)
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module axi4_reg_slice_chan #(
    parameter int W    = 8,
    parameter int MODE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         src_valid_i,
    output logic         src_ready_o,
    input  logic [W-1:0] src_data_i,
    output logic         dst_valid_o,
    input  logic         dst_ready_i,
    output logic [W-1:0] dst_data_o,
    output logic         empty_o
);

    generate
        if (MODE == 0) begin : g_bypass
            assign dst_valid_o = src_valid_i;
            assign dst_data_o  = src_data_i;
            assign src_ready_o = dst_ready_i;
            assign empty_o     = 1'b1;
        end else if (MODE == 1) begin : g_full
            logic         main_vld_q, main_vld_d, skid_vld_q, skid_vld_d, rdy_q;
            logic [W-1:0] main_dat_q, main_dat_d, skid_dat_q, skid_dat_d;
            logic         src_hs, dst_hs;

            always_comb begin
                src_hs     = src_valid_i & rdy_q;
                dst_hs     = main_vld_q & dst_ready_i;
                main_vld_d = main_vld_q;
                main_dat_d = main_dat_q;
                skid_vld_d = skid_vld_q;
                skid_dat_d = skid_dat_q;
                // src_ready is low whenever SKID is full, so no accept can collide with the refill
                if (dst_hs && skid_vld_q) begin
                    main_vld_d = 1'b1;
                    main_dat_d = skid_dat_q;
                    skid_vld_d = 1'b0;
                end else if (src_hs && (!main_vld_q || dst_hs)) begin
                    main_vld_d = 1'b1;
                    main_dat_d = src_data_i;
                end else begin
                    if (dst_hs) begin
                        main_vld_d = 1'b0;
                    end
                    if (src_hs) begin
                        skid_vld_d = 1'b1;
                        skid_dat_d = src_data_i;
                    end
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    main_vld_q <= 1'b0;
                    main_dat_q <= '0;
                    skid_vld_q <= 1'b0;
                    skid_dat_q <= '0;
                    rdy_q      <= 1'b0;
                end else begin
                    main_vld_q <= main_vld_d;
                    main_dat_q <= main_dat_d;
                    skid_vld_q <= skid_vld_d;
                    skid_dat_q <= skid_dat_d;
                    rdy_q      <= !skid_vld_d;
                end
            end

            assign src_ready_o = rdy_q;
            assign dst_valid_o = main_vld_q;
            assign dst_data_o  = main_dat_q;
            assign empty_o     = !main_vld_q && !skid_vld_q;
        end else if (MODE == 2) begin : g_light
            logic         main_vld_q, main_vld_d, rdy_q;
            logic [W-1:0] main_dat_q, main_dat_d;

            always_comb begin
                main_vld_d = main_vld_q;
                main_dat_d = main_dat_q;
                if (main_vld_q && dst_ready_i) begin
                    main_vld_d = 1'b0;
                end else if (src_valid_i && rdy_q) begin
                    main_vld_d = 1'b1;
                    main_dat_d = src_data_i;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    main_vld_q <= 1'b0;
                    main_dat_q <= '0;
                    rdy_q      <= 1'b0;
                end else begin
                    main_vld_q <= main_vld_d;
                    main_dat_q <= main_dat_d;
                    rdy_q      <= !main_vld_d;
                end
            end

            assign src_ready_o = rdy_q;
            assign dst_valid_o = main_vld_q;
            assign dst_data_o  = main_dat_q;
            assign empty_o     = !main_vld_q;
        end else begin : g_bad_mode
            $error("axi4_reg_slice_chan: MODE must be 0, 1 or 2");
            assign src_ready_o = 1'b0;
            assign dst_valid_o = 1'b0;
            assign dst_data_o  = '0;
            assign empty_o     = 1'b1;
        end
    endgenerate

endmodule

module axi4_reg_slice #(
    parameter int ID_W    = 6,
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 512,
    parameter int USER_W  = 1,
    parameter int AW_MODE = 1,
    parameter int W_MODE  = 1,
    parameter int B_MODE  = 1,
    parameter int AR_MODE = 1,
    parameter int R_MODE  = 1,
    localparam int AW_W   = ID_W + ADDR_W + 8 + 3 + 2 + 1 + 4 + 3 + 4 + 4 + USER_W,
    localparam int AR_W   = AW_W,
    localparam int W_W    = DATA_W + DATA_W / 8 + 1 + USER_W,
    localparam int B_W    = ID_W + 2 + USER_W,
    localparam int R_W    = ID_W + DATA_W + 2 + 1 + USER_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_aw_valid,
    output logic            s_aw_ready,
    input  logic [AW_W-1:0] s_aw_data,
    input  logic            s_w_valid,
    output logic            s_w_ready,
    input  logic [W_W-1:0]  s_w_data,
    output logic            s_b_valid,
    input  logic            s_b_ready,
    output logic [B_W-1:0]  s_b_data,
    input  logic            s_ar_valid,
    output logic            s_ar_ready,
    input  logic [AR_W-1:0] s_ar_data,
    output logic            s_r_valid,
    input  logic            s_r_ready,
    output logic [R_W-1:0]  s_r_data,
    output logic            m_aw_valid,
    input  logic            m_aw_ready,
    output logic [AW_W-1:0] m_aw_data,
    output logic            m_w_valid,
    input  logic            m_w_ready,
    output logic [W_W-1:0]  m_w_data,
    input  logic            m_b_valid,
    output logic            m_b_ready,
    input  logic [B_W-1:0]  m_b_data,
    output logic            m_ar_valid,
    input  logic            m_ar_ready,
    output logic [AR_W-1:0] m_ar_data,
    input  logic            m_r_valid,
    output logic            m_r_ready,
    input  logic [R_W-1:0]  m_r_data,
    output logic            idle
);

    logic [4:0] chan_empty;

    axi4_reg_slice_chan #(.W(AW_W), .MODE(AW_MODE)) u_aw (
        .clk(clk), .rst(rst),
        .src_valid_i(s_aw_valid), .src_ready_o(s_aw_ready), .src_data_i(s_aw_data),
        .dst_valid_o(m_aw_valid), .dst_ready_i(m_aw_ready), .dst_data_o(m_aw_data),
        .empty_o(chan_empty[0])
    );

    axi4_reg_slice_chan #(.W(W_W), .MODE(W_MODE)) u_w (
        .clk(clk), .rst(rst),
        .src_valid_i(s_w_valid), .src_ready_o(s_w_ready), .src_data_i(s_w_data),
        .dst_valid_o(m_w_valid), .dst_ready_i(m_w_ready), .dst_data_o(m_w_data),
        .empty_o(chan_empty[1])
    );

    // Response channels flow slave -> master
    axi4_reg_slice_chan #(.W(B_W), .MODE(B_MODE)) u_b (
        .clk(clk), .rst(rst),
        .src_valid_i(m_b_valid), .src_ready_o(m_b_ready), .src_data_i(m_b_data),
        .dst_valid_o(s_b_valid), .dst_ready_i(s_b_ready), .dst_data_o(s_b_data),
        .empty_o(chan_empty[2])
    );

    axi4_reg_slice_chan #(.W(AR_W), .MODE(AR_MODE)) u_ar (
        .clk(clk), .rst(rst),
        .src_valid_i(s_ar_valid), .src_ready_o(s_ar_ready), .src_data_i(s_ar_data),
        .dst_valid_o(m_ar_valid), .dst_ready_i(m_ar_ready), .dst_data_o(m_ar_data),
        .empty_o(chan_empty[3])
    );

    axi4_reg_slice_chan #(.W(R_W), .MODE(R_MODE)) u_r (
        .clk(clk), .rst(rst),
        .src_valid_i(m_r_valid), .src_ready_o(m_r_ready), .src_data_i(m_r_data),
        .dst_valid_o(s_r_valid), .dst_ready_i(s_r_ready), .dst_data_o(s_r_data),
        .empty_o(chan_empty[4])
    );

    assign idle = &chan_empty;

endmodule

`default_nettype wire

// File: tb/tb_axi4_reg_slice.sv
// ============================================================================
// tb_axi4_reg_slice : directed vector table plus random scoreboard for axi4_reg_slice
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_axi4_reg_slice;

    localparam int ID_W   = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int USER_W = 1;
    localparam int AW_W   = ID_W + ADDR_W + 8 + 3 + 2 + 1 + 4 + 3 + 4 + 4 + USER_W;
    localparam int AR_W   = AW_W;
    localparam int W_W    = DATA_W + DATA_W / 8 + 1 + USER_W;
    localparam int B_W    = ID_W + 2 + USER_W;
    localparam int R_W    = ID_W + DATA_W + 2 + 1 + USER_W;
    localparam int MAXW   = 80;
    localparam int NCYC   = 10000;

    // channel index: 0=AW 1=W 2=B 3=AR 4=R ; src/dst are flow direction of the channel
    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [4:0]      sv  = '0;
    logic [4:0]      dr  = '0;
    logic [MAXW-1:0] sd [5];
    wire  [4:0]      sr;
    wire  [4:0]      dv;
    wire             idle;
    wire  [AW_W-1:0] m_aw_data;
    wire  [W_W-1:0]  m_w_data;
    wire  [B_W-1:0]  s_b_data;
    wire  [AR_W-1:0] m_ar_data;
    wire  [R_W-1:0]  s_r_data;
    logic [MAXW-1:0] dd [5];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    axi4_reg_slice #(
        .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .USER_W(USER_W),
        .AW_MODE(1), .W_MODE(1), .B_MODE(0), .AR_MODE(1), .R_MODE(2)
    ) dut (
        .clk(clk), .rst(rst),
        .s_aw_valid(sv[0]), .s_aw_ready(sr[0]), .s_aw_data(sd[0][AW_W-1:0]),
        .s_w_valid(sv[1]),  .s_w_ready(sr[1]),  .s_w_data(sd[1][W_W-1:0]),
        .s_b_valid(dv[2]),  .s_b_ready(dr[2]),  .s_b_data(s_b_data),
        .s_ar_valid(sv[3]), .s_ar_ready(sr[3]), .s_ar_data(sd[3][AR_W-1:0]),
        .s_r_valid(dv[4]),  .s_r_ready(dr[4]),  .s_r_data(s_r_data),
        .m_aw_valid(dv[0]), .m_aw_ready(dr[0]), .m_aw_data(m_aw_data),
        .m_w_valid(dv[1]),  .m_w_ready(dr[1]),  .m_w_data(m_w_data),
        .m_b_valid(sv[2]),  .m_b_ready(sr[2]),  .m_b_data(sd[2][B_W-1:0]),
        .m_ar_valid(dv[3]), .m_ar_ready(dr[3]), .m_ar_data(m_ar_data),
        .m_r_valid(sv[4]),  .m_r_ready(sr[4]),  .m_r_data(sd[4][R_W-1:0]),
        .idle(idle)
    );

    always_comb begin
        dd[0] = MAXW'(m_aw_data);
        dd[1] = MAXW'(m_w_data);
        dd[2] = MAXW'(s_b_data);
        dd[3] = MAXW'(m_ar_data);
        dd[4] = MAXW'(s_r_data);
    end

    typedef struct {
        string           name;
        int              ch;
        logic            v;
        logic [MAXW-1:0] d;
        logic            r;
        logic            exp_sr;
        logic            exp_dv;
        logic            chk_dd;
        logic [MAXW-1:0] exp_dd;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [MAXW-1:0] act, input logic [MAXW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mkvec(input string name, input int ch, input logic v,
                                   input logic [MAXW-1:0] d, input logic r, input logic esr,
                                   input logic edv, input logic cdd, input logic [MAXW-1:0] edd);
        vec_t t;
        t.name = name; t.ch = ch; t.v = v; t.d = d; t.r = r;
        t.exp_sr = esr; t.exp_dv = edv; t.chk_dd = cdd; t.exp_dd = edd;
        return t;
    endfunction

    function automatic logic [MAXW-1:0] aw_beat(input int i);
        logic [AW_W-1:0] b;
        b = {4'(i), 32'h1000 + 32'(i) * 32'h40, 8'd0, 3'd6, 2'd1, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0, 1'b0};
        return MAXW'(b);
    endfunction

    function automatic logic [MAXW-1:0] w_beat(input int dat);
        logic [W_W-1:0] b;
        b = {32'(dat), 4'hF, 1'b1, 1'b0};
        return MAXW'(b);
    endfunction

    function automatic logic [MAXW-1:0] r_beat(input int k);
        logic [R_W-1:0] b;
        b = {4'(k), 32'hC0DE0000 + 32'(k), 2'b00, (k == 7), 1'b0};
        return MAXW'(b);
    endfunction

    function automatic logic [MAXW-1:0] chmask(input int ch);
        int w;
        case (ch)
            0:       w = AW_W;
            1:       w = W_W;
            2:       w = B_W;
            3:       w = AR_W;
            default: w = R_W;
        endcase
        return (MAXW'(1) << w) - MAXW'(1);
    endfunction

    function automatic logic [MAXW-1:0] mkdata(input int ch, input int seq);
        logic [31:0] s;
        logic [3:0]  c;
        s = 32'(seq);
        c = 4'(ch);
        return {s[15:0], s * 32'h85EBCA6B, (s * 32'h9E3779B9) ^ {c, 28'h0}};
    endfunction

    task automatic apply(input vec_t t);
        @(posedge clk); #1;
        sv[t.ch] = t.v;
        sd[t.ch] = t.d;
        dr[t.ch] = t.r;
        @(negedge clk);
        check({t.name, "/src_ready"}, MAXW'(sr[t.ch]), MAXW'(t.exp_sr));
        check({t.name, "/dst_valid"}, MAXW'(dv[t.ch]), MAXW'(t.exp_dv));
        if (t.chk_dd) check({t.name, "/dst_data"}, dd[t.ch], t.exp_dd);
        if (t.ch == 4 && t.exp_dv) check({t.name, "/rlast"}, MAXW'(s_r_data[1]), MAXW'(t.exp_dd[1]));
    endtask

    int              src_seq [5];
    int              dst_seq [5];
    logic [4:0]      stall;
    logic [4:0]      src_hs;
    logic [MAXW-1:0] prev_dd [5];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 5; i++) sd[i] = '0;

        // Power-on reset: buffered channels hold nothing and refuse traffic
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int ch = 0; ch < 5; ch++) begin
            if (ch != 2) begin
                check($sformatf("por_src_ready%0d", ch), MAXW'(sr[ch]), '0);
                check($sformatf("por_dst_valid%0d", ch), MAXW'(dv[ch]), '0);
                check($sformatf("por_dst_data%0d", ch), dd[ch], '0);
            end
        end
        check("por_idle", MAXW'(idle), MAXW'(1));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rel_aw_ready_before_edge", MAXW'(sr[0]), '0);
        @(negedge clk);
        check("rel_aw_ready_after_edge", MAXW'(sr[0]), MAXW'(1));

        // Fill AW MAIN+SKID, then reset mid-transfer
        @(posedge clk); #1;
        sv[0] = 1'b1; sd[0] = aw_beat(10); dr[0] = 1'b0;
        @(posedge clk); #1;
        sd[0] = aw_beat(11);
        @(posedge clk); #1;
        sv[0] = 1'b0;
        @(negedge clk);
        check("fill_aw_valid", MAXW'(dv[0]), MAXW'(1));
        check("fill_aw_data", dd[0], aw_beat(10));
        check("fill_aw_ready", MAXW'(sr[0]), '0);
        check("fill_idle", MAXW'(idle), '0);
        #2;
        rst = 1'b1;
        #1;
        check("rst_aw_valid", MAXW'(dv[0]), '0);
        check("rst_aw_ready", MAXW'(sr[0]), '0);
        check("rst_idle", MAXW'(idle), MAXW'(1));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst2_aw_ready_before_edge", MAXW'(sr[0]), '0);
        @(negedge clk);
        check("rst2_aw_ready_after_edge", MAXW'(sr[0]), MAXW'(1));
        check("rst2_aw_valid", MAXW'(dv[0]), '0);
        check("rst2_idle", MAXW'(idle), MAXW'(1));

        // AW full mode: 16 back-to-back, each out one cycle later
        for (int i = 0; i < 16; i++)
            tbl.push_back(mkvec($sformatf("aw_b2b%0d", i), 0, 1'b1, aw_beat(i), 1'b1,
                                1'b1, (i > 0), (i > 0), (i > 0) ? aw_beat(i - 1) : '0));
        tbl.push_back(mkvec("aw_b2b16", 0, 1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b1, aw_beat(15)));
        tbl.push_back(mkvec("aw_b2b17", 0, 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0, '0));

        // W full mode: sink stalls 3 cycles, only two beats fit
        tbl.push_back(mkvec("w_stall0", 1, 1'b1, w_beat('hA0), 1'b0, 1'b1, 1'b0, 1'b0, '0));
        tbl.push_back(mkvec("w_stall1", 1, 1'b1, w_beat('hA1), 1'b0, 1'b1, 1'b1, 1'b1, w_beat('hA0)));
        tbl.push_back(mkvec("w_stall2", 1, 1'b1, w_beat('hA2), 1'b0, 1'b0, 1'b1, 1'b1, w_beat('hA0)));
        tbl.push_back(mkvec("w_stall3", 1, 1'b1, w_beat('hA2), 1'b1, 1'b0, 1'b1, 1'b1, w_beat('hA0)));
        tbl.push_back(mkvec("w_stall4", 1, 1'b1, w_beat('hA2), 1'b1, 1'b1, 1'b1, 1'b1, w_beat('hA1)));
        tbl.push_back(mkvec("w_stall5", 1, 1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b1, w_beat('hA2)));
        tbl.push_back(mkvec("w_stall6", 1, 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0, '0));

        // B bypass: outputs follow inputs in the same cycle
        tbl.push_back(mkvec("b_byp0", 2, 1'b1, 80'h15, 1'b1, 1'b1, 1'b1, 1'b1, 80'h15));
        tbl.push_back(mkvec("b_byp1", 2, 1'b1, 80'h2A, 1'b0, 1'b0, 1'b1, 1'b1, 80'h2A));
        tbl.push_back(mkvec("b_byp2", 2, 1'b0, 80'h7F, 1'b1, 1'b1, 1'b0, 1'b1, 80'h7F));
        tbl.push_back(mkvec("b_byp3", 2, 1'b1, 80'h55, 1'b1, 1'b1, 1'b1, 1'b1, 80'h55));
        tbl.push_back(mkvec("b_byp4", 2, 1'b0, 80'h00, 1'b0, 1'b0, 1'b0, 1'b1, 80'h00));

        // R light mode: 8 beats, source always valid, one beat out every other cycle
        for (int c = 0; c <= 16; c++) begin
            int idx;
            idx = (c + 1) / 2;
            tbl.push_back(mkvec($sformatf("r_light%0d", c), 4, (idx < 8), (idx < 8) ? r_beat(idx) : '0,
                                1'b1, (c % 2 == 0), (c % 2 == 1), (c % 2 == 1),
                                (c % 2 == 1) ? r_beat((c - 1) / 2) : '0));
        end

        foreach (tbl[i]) apply(tbl[i]);

        @(posedge clk); #1;
        sv = '0; dr = '0;
        @(negedge clk);
        check("post_table_idle", MAXW'(idle), MAXW'(1));

        // Random traffic on all five channels, then drain
        for (int ch = 0; ch < 5; ch++) begin
            src_seq[ch] = 0; dst_seq[ch] = 0; prev_dd[ch] = '0;
            sd[ch] = mkdata(ch, 0) & chmask(ch);
        end
        stall = '0;
        src_hs = '0;
        for (int cyc = 0; cyc < NCYC + 20; cyc++) begin
            @(negedge clk);
            for (int ch = 0; ch < 5; ch++) begin
                logic sh, dh;
                sh = sv[ch] & sr[ch];
                dh = dv[ch] & dr[ch];
                if (stall[ch]) begin
                    check($sformatf("hold_valid%0d", ch), MAXW'(dv[ch]), MAXW'(1));
                    check($sformatf("hold_data%0d", ch), dd[ch], prev_dd[ch]);
                end
                if (dh) begin
                    check($sformatf("beat_exists%0d", ch), MAXW'(dst_seq[ch] < src_seq[ch] + int'(sh)), MAXW'(1));
                    check($sformatf("beat_order%0d", ch), dd[ch], mkdata(ch, dst_seq[ch]) & chmask(ch));
                    dst_seq[ch]++;
                end
                if (sh) src_seq[ch]++;
                src_hs[ch]  = sh;
                stall[ch]   = dv[ch] & ~dr[ch];
                prev_dd[ch] = dd[ch];
            end
            @(posedge clk); #1;
            for (int ch = 0; ch < 5; ch++) begin
                if (cyc >= NCYC) begin
                    sv[ch] = 1'b0;
                    dr[ch] = 1'b1;
                end else begin
                    if (!sv[ch] || src_hs[ch]) begin
                        sv[ch] = ($urandom_range(0, 99) < 70);
                        sd[ch] = mkdata(ch, src_seq[ch]) & chmask(ch);
                    end
                    dr[ch] = ($urandom_range(0, 99) < 60);
                end
            end
        end
        @(negedge clk);
        for (int ch = 0; ch < 5; ch++)
            check($sformatf("drain_count%0d", ch), MAXW'(dst_seq[ch]), MAXW'(src_seq[ch]));
        check("drain_idle", MAXW'(idle), MAXW'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
